gate_stim_checker: RTL and testbench
====================================

GATE_STIM_CHECKER -- requirements
Module: gate_stim_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning clock cycles each vector is held before its outputs are sampled; legal range 1..15.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: start  input  1  run request, sampled in IDLE only.
REQ-006 SHALL have port: a  output  1  stimulus A to the gates under test.
REQ-007 SHALL have port: b  output  1  stimulus B to the gates under test.
REQ-008 SHALL have inputs y_not, y_and, y_or, y_xor, y_nand, y_nor, y_xnor, each 1 bit, carrying the gate outputs under test.
REQ-009 SHALL have port: busy  output  1  high while a run is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse at run end.
REQ-011 SHALL have port: pass  output  1  last run had zero mismatches.
REQ-012 SHALL have port: err_count  output  5  total mismatches in last run, range 0..28.
REQ-013 SHALL have port: err_vec  output  7  sticky per-gate fail flags: [0]not [1]and [2]or [3]xor [4]nand [5]nor [6]xnor.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and DONE, plus a 2-bit vector index and a hold counter of at least 4 bits.
REQ-015 SHALL apply vectors in the order {a,b} = 00, 01, 10, 11.
REQ-016 SHALL, in IDLE on an edge with start=1: drive {a,b}<=00, set idx<=0, load the hold counter with SETTLE, set busy<=1, clear err_count, err_vec and pass, and go to WAIT.
REQ-017 SHALL, in WAIT, decrement the hold counter once per cycle and sample the seven y_* inputs on the SETTLE-th edge after the current vector was applied.
REQ-018 SHALL compute expected values from the registered a,b as: not=~a; and=a&b; or=a|b; xor=a^b; nand=~(a&b); nor=~(a|b); xnor=~(a^b).
REQ-019 SHALL, at each sample edge, add the number of mismatching gates (0..7) to err_count and OR the mismatch mask into err_vec.
REQ-020 SHALL, at a sample edge with idx<3: apply the next vector, increment idx and reload the hold counter in the same edge; each vector is held exactly SETTLE cycles.
REQ-021 SHALL, at the sample edge with idx=3: include that final sample in the results, set pass<=(final err_count==0), drive {a,b}<=00, set busy<=0 and done<=1, and go to DONE.
REQ-022 SHALL, in DONE, clear done and return to IDLE after exactly one cycle.
REQ-023 SHALL ignore start in DONE and whenever busy=1; no restart and no result clearing occurs in those cycles.
REQ-024 SHALL, with start held high continuously, begin a new run on the first edge in IDLE after DONE.
REQ-025 SHALL hold pass, err_count and err_vec stable from the end of a run until the next accepted start.
REQ-026 SHALL set total latency, from the start-accept edge to the edge asserting done, to 4*SETTLE cycles; for SETTLE=2 this is 8 cycles.
REQ-027 SHALL never wrap err_count; its maximum is 28, reached when all 7 gates fail all 4 vectors.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-run, immediately force: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, err_vec=0, idx=0 and hold counter=0.
REQ-029 SHALL require start to be re-asserted after reset release to begin a run; a start value held across reset is sampled only from the first post-release edge.

Verification
REQ-030 SHALL verify: correct gate models, SETTLE=2, start pulsed at edge 0 -> {a,b} sequence 00,01,10,11 at edges 0/2/4/6; done=1 at edge 8 only; pass=1, err_count=0, err_vec=0000000.
REQ-031 SHALL verify: y_and stuck at 0 -> err_count=1, err_vec=0000010, pass=0.
REQ-032 SHALL verify: y_xor inverted -> err_count=4, err_vec=0001000; all seven outputs inverted -> err_count=28, err_vec=1111111.
REQ-033 SHALL verify: start re-pulsed at edge 3 of a run -> run unaffected; done still at edge 8; exactly one done pulse.
REQ-034 SHALL verify: rst_n low at edge 5 of a run -> all outputs 0 asynchronously; a fresh start gives a complete correct run with pass=1.
REQ-035 SHALL verify: a failing run followed by a passing run -> results cleared at the second start-accept edge, and the final values are pass=1, err_count=0.

Source files
------------

// File: rtl/gate_stim_checker.sv
// gate_stim_checker
//   Drives the four two-input vectors {a,b} = 00, 01, 10, 11 onto a set of
//   gates under test. Each vector is held for SETTLE cycles. On the last cycle
//   of each hold, the seven gate outputs are compared with the expected values,
//   which are computed from the registered a/b.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      run request, sampled in IDLE only
//   a, b       stimulus to the gates under test
//   y_*        gate outputs under test (not, and, or, xor, nand, nor, xnor)
//   busy       high while a run is in progress
//   done       one-cycle pulse at run end
//   pass       last run had zero mismatches
//   err_count  total mismatches in last run (0..28)
//   err_vec    sticky per-gate fail flags:
//              [0]not [1]and [2]or [3]xor [4]nand [5]nor [6]xnor

module gate_stim_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y_not,
    input  logic       y_and,
    input  logic       y_or,
    input  logic       y_xor,
    input  logic       y_nand,
    input  logic       y_nor,
    input  logic       y_xnor,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [6:0] err_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(SETTLE);

    state_t     state_q, state_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] hold_q, hold_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] err_count_q, err_count_d;
    logic [6:0] err_vec_q, err_vec_d;

    logic [6:0] exp_y;
    logic [6:0] obs_y;
    logic [6:0] mism;
    logic [2:0] mism_cnt;
    logic [4:0] err_sum;

    always_comb begin
        exp_y = {~(a_q ^ b_q), ~(a_q | b_q), ~(a_q & b_q),
                 a_q ^ b_q, a_q | b_q, a_q & b_q, ~a_q};
        obs_y = {y_xnor, y_nor, y_nand, y_xor, y_or, y_and, y_not};
        mism  = exp_y ^ obs_y;

        mism_cnt = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            mism_cnt = mism_cnt + {2'b00, mism[i]};
        end
        err_sum = err_count_q + {2'b00, mism_cnt};
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_vec_d   = err_vec_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WAIT;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    idx_d       = '0;
                    hold_d      = HOLD_INIT;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    err_vec_d   = '0;
                end
            end

            S_WAIT: begin
                // hold_q == 1 marks the SETTLE-th edge since the vector was applied;
                // <= 1 also covers a stray zero so the FSM can never stall
                if (hold_q <= 4'd1) begin
                    err_count_d = err_sum;
                    err_vec_d   = err_vec_q | mism;
                    if (idx_q != 2'd3) begin
                        idx_d      = idx_q + 2'd1;
                        {a_d, b_d} = idx_q + 2'd1;
                        hold_d     = HOLD_INIT;
                    end else begin
                        state_d = S_DONE;
                        pass_d  = (err_sum == 5'd0);
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end

            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            idx_q       <= '0;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_vec_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_vec_q   <= err_vec_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_vec   = err_vec_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
module tb_gate_stim_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       a, b;
    logic [6:0] y;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [6:0] err_vec;

    // gate-under-test fault mode: 0 good, 1 and stuck-0, 2 xor inverted, 3 all inverted
    int unsigned mode;

    int checks;
    int errors;

    gate_stim_checker #(.SETTLE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .y_not     (y[0]),
        .y_and     (y[1]),
        .y_or      (y[2]),
        .y_xor     (y[3]),
        .y_nand    (y[4]),
        .y_nor     (y[5]),
        .y_xnor    (y[6]),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .err_vec   (err_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        y = {~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b, ~a};
        case (mode)
            1: y[1] = 1'b0;
            2: y[3] = ~y[3];
            3: y = ~y;
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full run; edge 0 is the start-accept edge. Samples on the negedge after each edge.
    task automatic do_run(input int repulse, input logic [4:0] exp_cnt, input logic [6:0] exp_vec);
        int dones;
        dones = 0;
        @(negedge clk) start = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            @(negedge clk);
            if (e == 0) start = 1'b0;
            if (e == repulse - 1) start = 1'b1;
            if (e == repulse) start = 1'b0;
            if (e == 0) begin
                check_eq("clr_cnt", 32'(err_count), 32'd0);
                check_eq("clr_vec", 32'(err_vec), 32'd0);
                check_eq("clr_pass", 32'(pass), 32'd0);
            end
            if (e < 8 && (e % 2) == 0)
                check_eq($sformatf("ab_e%0d", e), 32'({a, b}), 32'(e / 2));
            check_eq($sformatf("done_e%0d", e), 32'(done), 32'(e == 8));
            check_eq($sformatf("busy_e%0d", e), 32'(busy), 32'(e < 8));
            dones += int'(done);
        end
        check_eq("done_pulses", 32'(dones), 32'd1);
        check_eq("err_count", 32'(err_count), 32'(exp_cnt));
        check_eq("err_vec", 32'(err_vec), 32'(exp_vec));
        check_eq("pass", 32'(pass), 32'(exp_cnt == 5'd0));
        check_eq("ab_end", 32'({a, b}), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ab"}, 32'({a, b}), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass), 32'd0);
        check_eq({tag, "_cnt"}, 32'(err_count), 32'd0);
        check_eq({tag, "_vec"}, 32'(err_vec), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mode   = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;

        do_run(-1, 5'd0, 7'b0000000);
        mode = 1;
        do_run(-1, 5'd1, 7'b0000010);
        mode = 2;
        do_run(-1, 5'd4, 7'b0001000);
        mode = 3;
        do_run(-1, 5'd28, 7'b1111111);
        // passing run straight after a failing one: results cleared at accept
        mode = 0;
        do_run(-1, 5'd0, 7'b0000000);
        // start re-pulsed mid-run must be ignored
        do_run(3, 5'd0, 7'b0000000);

        // reset mid-run, with errors already accumulated by edge 5
        mode = 3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_cnt", 32'(err_count), 32'd14);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        mode = 0;
        do_run(-1, 5'd0, 7'b0000000);

        // start held high: next run accepted on the first IDLE edge after DONE
        @(negedge clk) start = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            @(negedge clk);
            if (e == 8) check_eq("held_done", 32'(done), 32'd1);
            if (e == 9) check_eq("held_idle_busy", 32'(busy), 32'd0);
            if (e == 10) check_eq("held_restart_busy", 32'(busy), 32'd1);
        end
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
